// File: rtl/lb1_window_gen.sv
// lb1_window_gen: raster-scan 3x3 window generator built on two line buffers.
// Ports: lbw_clk/lbw_rst (async high), frame_clr_i, pxl_valid_i, pxl_i in;
//        win_o (9 packed pixels, k=r*3+c), win_valid_o, frame_done_o out.
module lb1_window_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int IMG_COL_WIDTH = 3,
  parameter int IMG_ROW_WIDTH = 3
) (
  input  logic                    lbw_clk,
  input  logic                    lbw_rst,
  input  logic                    frame_clr_i,
  input  logic                    pxl_valid_i,
  input  logic [DATA_WIDTH-1:0]   pxl_i,
  output logic [9*DATA_WIDTH-1:0] win_o,
  output logic                    win_valid_o,
  output logic                    frame_done_o
);

  localparam int COLS = 1 << IMG_COL_WIDTH;
  localparam int DW   = DATA_WIDTH;

  localparam logic [IMG_COL_WIDTH-1:0] COL2 = 2;
  localparam logic [IMG_ROW_WIDTH-1:0] ROW2 = 2;

  logic [IMG_COL_WIDTH-1:0] col;
  logic [IMG_ROW_WIDTH-1:0] row;

  logic [DW-1:0] lb0_mem [COLS];
  logic [DW-1:0] lb1_mem [COLS];
  logic [DW-1:0] lb0_q;
  logic [DW-1:0] lb1_q;

  logic          accept;
  logic          col_max;
  logic          row_max;
  logic          in_win;
  logic [9*DW-1:0] win_nxt;

  // Clear wins over a presented pixel.
  assign accept  = pxl_valid_i & ~frame_clr_i;
  assign col_max = &col;
  assign row_max = &row;
  assign in_win  = (row >= ROW2) && (col >= COL2);

  // Indexed by the current column, each buffer returns what was
  // written at this column one (lb0) or two (lb1) rows ago.
  assign lb0_q = lb0_mem[col];
  assign lb1_q = lb1_mem[col];

  always_ff @(posedge lbw_clk) begin
    if (accept) begin
      lb0_mem[col] <= pxl_i;
      lb1_mem[col] <= lb0_q;
    end
  end

  always_ff @(posedge lbw_clk or posedge lbw_rst) begin
    if (lbw_rst) begin
      col <= '0;
      row <= '0;
    end else if (frame_clr_i) begin
      col <= '0;
      row <= '0;
    end else if (pxl_valid_i) begin
      col <= col + 1'b1;
      if (col_max) begin
        row <= row + 1'b1;
      end
    end
  end

  // Shift left one column, new right column from lb1/lb0/pixel.
  always_comb begin
    win_nxt = win_o;
    for (int r = 0; r < 3; r++) begin
      win_nxt[(r*3)*DW +: DW]   = win_o[(r*3+1)*DW +: DW];
      win_nxt[(r*3+1)*DW +: DW] = win_o[(r*3+2)*DW +: DW];
    end
    win_nxt[2*DW +: DW] = lb1_q;
    win_nxt[5*DW +: DW] = lb0_q;
    win_nxt[8*DW +: DW] = pxl_i;
  end

  always_ff @(posedge lbw_clk or posedge lbw_rst) begin
    if (lbw_rst) begin
      win_o        <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      win_valid_o  <= accept & in_win;
      frame_done_o <= accept & row_max & col_max;
      if (accept) begin
        win_o <= win_nxt;
      end
    end
  end

endmodule
